// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes on both sides.
//
// Single-cycle ops (ADD, SUB, SLL, SRL, OR, AND, XOR) load the output register
// on the accept edge. MUL is an unsigned shift-and-add over WIDTH cycles and
// back-pressures the input while it runs. Illegal opcodes complete as
// single-cycle ops with result 0 and err_f set.
//
// Build option: define ALU_PIPE_MUL_EN to build the multiplier. Without it,
// opcode 8'h80 is illegal and the control stays idle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake for opcode/op_0/op_1
//   opcode            one-hot: ADD,SUB,SLL,SRL,OR,AND,XOR,MUL (bit0..bit7)
//   op_0, op_1        operands (op_1 is the shift amount for shifts)
//   out_valid/out_ready output handshake for result and flags
//   result            registered result
//   zero_f, neg_f, carry_f, ovf_f, err_f  registered flags
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       opcode,
    input  logic [WIDTH-1:0] op_0,
    input  logic [WIDTH-1:0] op_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_f,
    output logic             neg_f,
    output logic             carry_f,
    output logic             ovf_f,
    output logic             err_f
);

    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    logic             out_free;
    logic             accept;
    logic             onehot;
    logic             mul_op;
    logic             legal;
    logic             load_sc;
    logic             load_mul;

    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic             sc_ovf;

    logic [WIDTH-1:0] res_d,   res_q;
    logic             valid_d, valid_q;
    logic             zero_d,  zero_q;
    logic             neg_d,   neg_q;
    logic             carry_d, carry_q;
    logic             ovf_d,   ovf_q;
    logic             err_d,   err_q;

    assign out_free = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign onehot   = (opcode != '0) && ((opcode & (opcode - 8'd1)) == '0);
    // Without the multiplier, bit7 fails this check and falls into the error path.
    assign legal    = onehot && (mul_op || !opcode[7]);
    assign load_sc  = accept && !mul_op;

`ifdef ALU_PIPE_MUL_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] prod_q;

    assign mul_op   = onehot && opcode[7];
    assign in_ready = (state_q == IDLE) && out_free;
    assign load_mul = (state_q == DONE) && out_free;

    // Operands are captured at accept; BUSY runs WIDTH steps (counter WIDTH-1..0),
    // and DONE waits for the output register to be free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && mul_op) begin
                        state_q  <= BUSY;
                        cnt_q    <= CNT_INIT;
                        mcand_q  <= {{WIDTH{1'b0}}, op_0};
                        mplier_q <= op_1;
                        prod_q   <= '0;
                    end
                end
                BUSY: begin
                    if (mplier_q[0]) begin
                        prod_q <= prod_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_free) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    assign mul_op   = 1'b0;
    assign in_ready = out_free;
    assign load_mul = 1'b0;
`endif

    // Single-cycle datapath; illegal opcodes leave everything at zero.
    always_comb begin
        add_full = {1'b0, op_0} + {1'b0, op_1};
        sub_full = {1'b0, op_0} - {1'b0, op_1};
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        if (legal) begin
            case (opcode)
                8'h01: begin
                    sc_res   = add_full[WIDTH-1:0];
                    sc_carry = add_full[WIDTH];
                    sc_ovf   = (op_0[WIDTH-1] == op_1[WIDTH-1]) &&
                               (add_full[WIDTH-1] != op_0[WIDTH-1]);
                end
                8'h02: begin
                    sc_res   = sub_full[WIDTH-1:0];
                    // Borrow out of the extended subtraction equals op_0 < op_1.
                    sc_carry = sub_full[WIDTH];
                    sc_ovf   = (op_0[WIDTH-1] != op_1[WIDTH-1]) &&
                               (sub_full[WIDTH-1] != op_0[WIDTH-1]);
                end
                8'h04:   sc_res = (op_1 >= WIDTH_V) ? '0 : (op_0 << op_1);
                8'h08:   sc_res = (op_1 >= WIDTH_V) ? '0 : (op_0 >> op_1);
                8'h10:   sc_res = op_0 | op_1;
                8'h20:   sc_res = op_0 & op_1;
                8'h40:   sc_res = op_0 ^ op_1;
                default: sc_res = '0;
            endcase
        end
    end

    // Output register: a load wins over consumption, so a result can be
    // replaced on the same edge it is taken.
    always_comb begin
        res_d   = res_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        valid_d = valid_q && !out_ready;
        if (load_sc) begin
            res_d   = sc_res;
            zero_d  = (sc_res == '0);
            neg_d   = sc_res[WIDTH-1];
            carry_d = sc_carry;
            ovf_d   = sc_ovf;
            err_d   = !legal;
            valid_d = 1'b1;
        end
`ifdef ALU_PIPE_MUL_EN
        if (load_mul) begin
            res_d   = prod_q[WIDTH-1:0];
            zero_d  = (prod_q[WIDTH-1:0] == '0);
            neg_d   = prod_q[WIDTH-1];
            carry_d = |prod_q[2*WIDTH-1:WIDTH];
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            valid_q <= 1'b0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign result    = res_q;
    assign zero_f    = zero_q;
    assign neg_f     = neg_q;
    assign carry_f   = carry_q;
    assign ovf_f     = ovf_q;
    assign err_f     = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH = 8).
// A transaction-level model predicts each accepted operation's result and
// flags; a negedge monitor checks every consumed result, hold stability and
// in_ready. Directed sequences pin latency, back-pressure, MUL and reset abort.
// Honours ALU_PIPE_MUL_EN the same way as the design.
module tb_alu_pipe;

    localparam int W = 8;
`ifdef ALU_PIPE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] res;
        logic         zf;
        logic         nf;
        logic         cf;
        logic         vf;
        logic         ef;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   opcode;
    logic [W-1:0] op_0;
    logic [W-1:0] op_1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero_f;
    logic         neg_f;
    logic         carry_f;
    logic         ovf_f;
    logic         err_f;

    int total = 0;
    int bad   = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .op_0      (op_0),
        .op_1      (op_1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero_f    (zero_f),
        .neg_f     (neg_f),
        .carry_f   (carry_f),
        .ovf_f     (ovf_f),
        .err_f     (err_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic z, input logic n,
                                input logic c, input logic v, input logic e);
        exp_t x;
        x.res = r; x.zf = z; x.nf = n; x.cf = c; x.vf = v; x.ef = e;
        return x;
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [7:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        longint ua, ub, lim, sa, sb, r, s;
        exp_t x;
        ua  = longint'(a);
        ub  = longint'(b);
        lim = longint'(1) << W;
        sa  = a[W-1] ? ua - lim : ua;
        sb  = b[W-1] ? ub - lim : ub;
        x   = '0;
        r   = 0;
        if ($countones(op) != 1 || (op == 8'h80 && !MUL_EN)) begin
            x.ef = 1'b1;
        end else begin
            case (op)
                8'h01: begin
                    r = ua + ub; x.cf = (r >= lim);
                    s = sa + sb; x.vf = (s >= lim / 2) || (s < -(lim / 2));
                end
                8'h02: begin
                    r = ua - ub; x.cf = (ua < ub);
                    s = sa - sb; x.vf = (s >= lim / 2) || (s < -(lim / 2));
                end
                8'h04: r = (ub >= W) ? 0 : (ua << ub);
                8'h08: r = (ub >= W) ? 0 : (ua >> ub);
                8'h10: r = ua | ub;
                8'h20: r = ua & ub;
                8'h40: r = ua ^ ub;
                default: begin
                    r = ua * ub; x.cf = (r >= lim);
                end
            endcase
        end
        x.res = r[W-1:0];
        x.zf  = (x.res == '0);
        x.nf  = x.res[W-1];
        return x;
    endfunction

    function automatic exp_t dut_now();
        exp_t x;
        x = {result, zero_f, neg_f, carry_f, ovf_f, err_f};
        return x;
    endfunction

    // Monitor: decides at each negedge what the coming edge will do.
    exp_t q[$];
    exp_t snap;
    exp_t front;
    logic held = 1'b0;
    int   inflight;
    logic exp_ir;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            held = 1'b0;
        end else begin
            if (held) chk("hold stable", 64'(dut_now()), 64'(snap));
            if (out_valid && q.size() == 0) chk("spurious out_valid", 64'(out_valid), 64'(0));
            inflight = q.size() - int'(out_valid);
            exp_ir   = (inflight == 0) && (!out_valid || out_ready);
            chk("in_ready", 64'(in_ready), 64'(exp_ir));
            if (out_valid && out_ready && q.size() != 0) begin
                front = q.pop_front();
                chk("result+flags", 64'(dut_now()), 64'(front));
            end
            if (in_valid && in_ready) q.push_back(model(opcode, op_0, op_1));
            held = out_valid && !out_ready;
            snap = dut_now();
        end
    end

    task automatic single(input string nm, input logic [7:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input exp_t e);
        in_valid = 1'b1; opcode = op; op_0 = a; op_1 = b; out_ready = 1'b1;
        @(negedge clk);
        chk({nm, " in_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; op_0 = ~a; op_1 = ~b;
        @(negedge clk);
        chk({nm, " out_valid"}, 64'(out_valid), 64'(1));
        chk({nm, " value"}, 64'(dut_now()), 64'(e));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; opcode = '0; op_0 = '0; op_1 = '0; out_ready = 1'b0;

        // Pin the model to hand-computed values.
        chk("model add", 64'(model(8'h01, 8'hFF, 8'h01)), 64'(mk(8'h00, 1, 0, 1, 0, 0)));
        chk("model sub ovf", 64'(model(8'h02, 8'h80, 8'h01)), 64'(mk(8'h7F, 0, 0, 0, 1, 0)));
        chk("model sub borrow", 64'(model(8'h02, 8'h01, 8'h02)), 64'(mk(8'hFF, 0, 1, 1, 0, 0)));
        chk("model sll", 64'(model(8'h04, 8'h81, 8'h01)), 64'(mk(8'h02, 0, 0, 0, 0, 0)));
        chk("model srl", 64'(model(8'h08, 8'h81, 8'h01)), 64'(mk(8'h40, 0, 0, 0, 0, 0)));
        chk("model sll 8", 64'(model(8'h04, 8'h01, 8'h08)), 64'(mk(8'h00, 1, 0, 0, 0, 0)));
        chk("model illegal", 64'(model(8'h03, 8'h12, 8'h34)), 64'(mk(8'h00, 1, 0, 0, 0, 1)));
`ifdef ALU_PIPE_MUL_EN
        chk("model mul", 64'(model(8'h80, 8'h10, 8'h11)), 64'(mk(8'h10, 0, 0, 1, 0, 0)));
`else
        chk("model mul off", 64'(model(8'h80, 8'h10, 8'h11)), 64'(mk(8'h00, 1, 0, 0, 0, 1)));
`endif

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset value", 64'(dut_now()), 64'(mk(8'h00, 1, 0, 0, 0, 0)));
        chk("reset in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        single("add", 8'h01, 8'hFF, 8'h01, mk(8'h00, 1, 0, 1, 0, 0));
        single("sub ovf", 8'h02, 8'h80, 8'h01, mk(8'h7F, 0, 0, 0, 1, 0));
        single("sub borrow", 8'h02, 8'h01, 8'h02, mk(8'hFF, 0, 1, 1, 0, 0));
        single("sll", 8'h04, 8'h81, 8'h01, mk(8'h02, 0, 0, 0, 0, 0));
        single("srl", 8'h08, 8'h81, 8'h01, mk(8'h40, 0, 0, 0, 0, 0));
        single("sll 8", 8'h04, 8'h01, 8'h08, mk(8'h00, 1, 0, 0, 0, 0));
        single("illegal 03", 8'h03, 8'h55, 8'h0F, mk(8'h00, 1, 0, 0, 0, 1));
        single("illegal 00", 8'h00, 8'hAA, 8'h01, mk(8'h00, 1, 0, 0, 0, 1));
`ifndef ALU_PIPE_MUL_EN
        single("illegal 80", 8'h80, 8'h10, 8'h11, mk(8'h00, 1, 0, 0, 0, 1));
`endif

        // Back-pressure: three ADDs while the consumer stalls, then drain.
        out_ready = 1'b0; in_valid = 1'b1; opcode = 8'h01; op_0 = 8'h10; op_1 = 8'h01;
        @(negedge clk);
        chk("bp first in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        op_0 = 8'h20; op_1 = 8'h02;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp held result", 64'(result), 64'(8'h11));
            chk("bp held valid", 64'(out_valid), 64'(1));
            chk("bp stall in_ready", 64'(in_ready), 64'(0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp release in_ready", 64'(in_ready), 64'(1));
        chk("bp drain 1", 64'(result), 64'(8'h11));
        @(posedge clk); #1;
        op_0 = 8'h7F; op_1 = 8'h01;
        @(negedge clk);
        chk("bp drain 2", 64'(result), 64'(8'h22));
        chk("bp drain 2 valid", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp drain 3", 64'(dut_now()), 64'(mk(8'h80, 0, 1, 0, 1, 0)));
        chk("bp drain 3 valid", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp empty", 64'(out_valid), 64'(0));
        @(posedge clk); #1;

`ifdef ALU_PIPE_MUL_EN
        // MUL latency: accept at edge N, result after edge N+W+1.
        in_valid = 1'b1; opcode = 8'h80; op_0 = 8'h10; op_1 = 8'h11; out_ready = 1'b1;
        @(negedge clk);
        chk("mul accept", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; op_0 = 8'hFF; op_1 = 8'hFF;
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            chk("mul busy out_valid", 64'(out_valid), 64'(0));
            chk("mul busy in_ready", 64'(in_ready), 64'(0));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("mul out_valid", 64'(out_valid), 64'(1));
        chk("mul value", 64'(dut_now()), 64'(mk(8'h10, 0, 0, 1, 0, 0)));
        @(posedge clk); #1;

        // Reset on the 4th edge after a MUL accept aborts it.
        in_valid = 1'b1; opcode = 8'h80; op_0 = 8'h10; op_1 = 8'h11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort busy in_ready", 64'(in_ready), 64'(0));
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort in_ready", 64'(in_ready), 64'(1));
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            chk("abort out_valid", 64'(out_valid), 64'(0));
            @(posedge clk); #1;
        end
`endif

        // Randomised traffic with a reset dropped in mid-stream.
        for (int c = 0; c < 3000; c++) begin
            rst      = (c == 1500);
            in_valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) < 88) opcode = 8'(1 << $urandom_range(0, 7));
            else                            opcode = 8'($urandom);
            op_0 = W'($urandom);
            if ($urandom_range(0, 1) == 1) op_1 = W'($urandom_range(0, W + 1));
            else                           op_1 = W'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (W + 4) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain pending", 64'(q.size()), 64'(0));
        chk("drain out_valid", 64'(out_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
